fp_exp_align_stage: RTL and testbench



---
 rtl/fp_pkg.sv | 16 +
 rtl/fp_exp_align_stage_if.sv | 29 ++
 rtl/fp_skid_buf.sv | 41 ++++
 rtl/fp_exp_align_stage.sv | 50 +++++
 tb/tb_fp_exp_align_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, constants and the aligned-beat record for the FP adder front end.
// Contents: EXP_W, MANT_W, DIFF_W, DIFF_MAX and align_beat_t (the payload carried by fp_skid_buf).
package fp_pkg;
   localparam int EXP_W = 4;
   localparam int MANT_W = 8;
   localparam int DIFF_W = 3;
   localparam int DIFF_MAX = 7;
   typedef struct packed {
      logic [EXP_W-1:0] big_exp;
      logic [MANT_W-1:0] big_mant;
      logic [MANT_W-1:0] small_mant;
      logic [DIFF_W-1:0] diff;
      logic shift_ovf;
      logic swapped;
   } align_beat_t;
endpackage

// File: rtl/fp_exp_align_stage_if.sv
// fp_exp_align_stage_if: operand-pair input channel and aligned-result output channel.
// Input channel: in_valid, in_ready, a_exp, a_mant, b_exp, b_mant.
// Output channel: out_valid, out_ready, big_exp, big_mant, small_mant, diff, shift_ovf, swapped.
// master: the environment (drives operands and out_ready); slave: the align stage.
interface fp_exp_align_stage_if;
   import fp_pkg::*;
   logic in_valid;
   logic in_ready;
   logic [EXP_W-1:0] a_exp;
   logic [MANT_W-1:0] a_mant;
   logic [EXP_W-1:0] b_exp;
   logic [MANT_W-1:0] b_mant;
   logic out_valid;
   logic out_ready;
   logic [EXP_W-1:0] big_exp;
   logic [MANT_W-1:0] big_mant;
   logic [MANT_W-1:0] small_mant;
   logic [DIFF_W-1:0] diff;
   logic shift_ovf;
   logic swapped;
   modport master (
      output in_valid, a_exp, a_mant, b_exp, b_mant, out_ready,
      input in_ready, out_valid, big_exp, big_mant, small_mant, diff, shift_ovf, swapped
   );
   modport slave (
      input in_valid, a_exp, a_mant, b_exp, b_mant, out_ready,
      output in_ready, out_valid, big_exp, big_mant, small_mant, diff, shift_ovf, swapped
   );
endinterface

// File: rtl/fp_skid_buf.sv
// fp_skid_buf: 2-entry valid/ready skid buffer (output slot + skid slot) for any packed payload T.
// Ports: clk, rst_n (async active-low), in_valid/in_ready/in_data upstream,
//        out_valid/out_ready/out_data downstream. in_ready is a flop meaning "skid slot empty".
module fp_skid_buf import fp_pkg::*; #(
   parameter type T = align_beat_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);
   T skid_data;
   logic accept, drain;
   assign accept = in_valid && in_ready;
   assign drain = out_valid && out_ready;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data <= '0;
         in_ready <= 1'b1;
         skid_data <= '0;
      end else if (!in_ready) begin
         if (drain) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
         end
      end else if (accept) begin
         if (!out_valid || drain) begin
            out_data <= in_data;
            out_valid <= 1'b1;
         end else begin
            skid_data <= in_data;
            in_ready <= 1'b0;
         end
      end else if (drain)
         out_valid <= 1'b0;
endmodule

// File: rtl/fp_exp_align_stage.sv
// fp_exp_align_stage: picks the larger-exponent operand and a saturated right-shift amount for the smaller mantissa.
// Ports: clk, rst_n (async active-low), bus (fp_exp_align_stage_if.slave): operand pair in, aligned beat out.
// Macro FP_ALIGN_ZERO_DETECT_EN: a zero mantissa is always treated as the small operand (fully shifted out).
module fp_exp_align_stage import fp_pkg::*; (
   input logic clk,
   input logic rst_n,
   fp_exp_align_stage_if.slave bus
);
   logic ge, ovf, swap;
   logic [EXP_W-1:0] raw;
   align_beat_t beat, q;
   assign ge = bus.a_exp >= bus.b_exp;
   assign raw = ge ? bus.a_exp - bus.b_exp : bus.b_exp - bus.a_exp;
   assign ovf = raw > EXP_W'(DIFF_MAX);
`ifdef FP_ALIGN_ZERO_DETECT_EN
   logic az, bz, one_zero, both_zero;
   assign az = bus.a_mant == '0;
   assign bz = bus.b_mant == '0;
   assign one_zero = az ^ bz;
   assign both_zero = az && bz;
   // a lone zero mantissa loses; a zero B (or two zeros) keeps A on the big side
   assign swap = (az && !bz) ? 1'b1 : bz ? 1'b0 : !ge;
   assign beat.shift_ovf = both_zero ? 1'b0 : one_zero ? 1'b1 : ovf;
   assign beat.diff = both_zero ? '0 : (one_zero || ovf) ? DIFF_W'(DIFF_MAX) : raw[DIFF_W-1:0];
`else
   assign swap = !ge;
   assign beat.shift_ovf = ovf;
   assign beat.diff = ovf ? DIFF_W'(DIFF_MAX) : raw[DIFF_W-1:0];
`endif
   assign beat.swapped = swap;
   assign beat.big_exp = swap ? bus.b_exp : bus.a_exp;
   assign beat.big_mant = swap ? bus.b_mant : bus.a_mant;
   assign beat.small_mant = swap ? bus.a_mant : bus.b_mant;
   fp_skid_buf #(.T(align_beat_t)) u_skid (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(bus.in_valid),
      .in_ready(bus.in_ready),
      .in_data(beat),
      .out_valid(bus.out_valid),
      .out_ready(bus.out_ready),
      .out_data(q)
   );
   assign bus.big_exp = q.big_exp;
   assign bus.big_mant = q.big_mant;
   assign bus.small_mant = q.small_mant;
   assign bus.diff = q.diff;
   assign bus.shift_ovf = q.shift_ovf;
   assign bus.swapped = q.swapped;
endmodule

// File: tb/tb_fp_exp_align_stage.sv
// tb_fp_exp_align_stage: scoreboard bench for fp_exp_align_stage with hand-computed directed vectors.
module tb_fp_exp_align_stage;
   import fp_pkg::*;
   typedef struct {
      logic [3:0] ae;
      logic [7:0] am;
      logic [3:0] be;
      logic [7:0] bm;
      align_beat_t e;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   bit stress_done = 1'b0;
   vec_t vt[$];
   align_beat_t sb[$];
   align_beat_t now_beat;
   fp_exp_align_stage_if bus ();
   fp_exp_align_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   assign now_beat = {bus.big_exp, bus.big_mant, bus.small_mant, bus.diff, bus.shift_ovf, bus.swapped};
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask
   function automatic void add(input logic [3:0] ae, input logic [7:0] am, input logic [3:0] be,
                               input logic [7:0] bm, input logic [3:0] ge, input logic [7:0] gm,
                               input logic [7:0] sm, input logic [2:0] d, input logic o, input logic s);
      vec_t v;
      v.ae = ae;
      v.am = am;
      v.be = be;
      v.bm = bm;
      v.e = {ge, gm, sm, d, o, s};
      vt.push_back(v);
   endfunction
   task automatic send(input int k);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.a_exp = vt[k].ae;
      bus.a_mant = vt[k].am;
      bus.b_exp = vt[k].be;
      bus.b_mant = vt[k].bm;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.in_ready && t < 100);
      if (!bus.in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stuck at 0 for vector %0d", k);
      end else
         sb.push_back(vt[k].e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask
   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: %0d beats still pending", sb.size());
      end
      @(posedge clk);
      #1;
   endtask
   // monitor: pops the scoreboard on every output transfer and checks stability across stalls
   initial begin
      align_beat_t held;
      bit held_v = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held_v = 1'b0;
            continue;
         end
         if (held_v && bus.out_valid) chk("stall_stable", 32'(now_beat), 32'(held));
         if (held_v && !bus.out_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL stall_valid: got out_valid 0 while stalled, expected 1");
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_beat: got %h, expected no output", now_beat);
            end else
               chk("beat", 32'(now_beat), 32'(sb.pop_front()));
            held_v = 1'b0;
         end else if (bus.out_valid) begin
            held = now_beat;
            held_v = 1'b1;
         end else
            held_v = 1'b0;
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
   initial begin
      add(4'd5, 8'hC0, 4'd2, 8'hA0, 4'd5, 8'hC0, 8'hA0, 3'd3, 1'b0, 1'b0);
      add(4'd1, 8'h11, 4'd12, 8'h22, 4'd12, 8'h22, 8'h11, 3'd7, 1'b1, 1'b1);
      add(4'd9, 8'h33, 4'd9, 8'h44, 4'd9, 8'h33, 8'h44, 3'd0, 1'b0, 1'b0);
      add(4'd3, 8'h55, 4'd10, 8'h66, 4'd10, 8'h66, 8'h55, 3'd7, 1'b0, 1'b1);
      add(4'd15, 8'h77, 4'd7, 8'h88, 4'd15, 8'h77, 8'h88, 3'd7, 1'b1, 1'b0);
      add(4'd0, 8'h99, 4'd15, 8'hAA, 4'd15, 8'hAA, 8'h99, 3'd7, 1'b1, 1'b1);
      add(4'd6, 8'hBB, 4'd7, 8'hCC, 4'd7, 8'hCC, 8'hBB, 3'd1, 1'b0, 1'b1);
      add(4'd15, 8'hDD, 4'd15, 8'hEE, 4'd15, 8'hDD, 8'hEE, 3'd0, 1'b0, 1'b0);
      add(4'd0, 8'hF1, 4'd0, 8'hF2, 4'd0, 8'hF1, 8'hF2, 3'd0, 1'b0, 1'b0);
`ifdef FP_ALIGN_ZERO_DETECT_EN
      add(4'd14, 8'h00, 4'd3, 8'h80, 4'd3, 8'h80, 8'h00, 3'd7, 1'b1, 1'b1);
      add(4'd2, 8'h00, 4'd2, 8'h00, 4'd2, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      add(4'd1, 8'h90, 4'd13, 8'h00, 4'd1, 8'h90, 8'h00, 3'd7, 1'b1, 1'b0);
`else
      add(4'd14, 8'h00, 4'd3, 8'h80, 4'd14, 8'h00, 8'h80, 3'd7, 1'b1, 1'b0);
`endif
      bus.in_valid = 1'b0;
      bus.a_exp = '0;
      bus.a_mant = '0;
      bus.b_exp = '0;
      bus.b_mant = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset_data", 32'(now_beat), 32'd0);
      @(posedge clk);
      #1;
      for (int k = 0; k < vt.size(); k++) begin
         send(k);
         chk("latency", 32'(bus.out_valid), 32'd1);
         drain();
         chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
      end
      bus.out_ready = 1'b0;
      fork
         begin
            send(0);
            send(1);
            send(2);
         end
         begin
            repeat (3) @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
      chk("bp_empty", 32'(bus.out_valid), 32'd0);
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               while ($urandom_range(1) == 1) begin
                  bus.in_valid = 1'b0;
                  @(posedge clk);
                  #1;
               end
               send($urandom_range(vt.size() - 1));
            end
            stress_done = 1'b1;
         end
         begin
            while (!stress_done) begin
               bus.out_ready = 1'($urandom_range(1));
               @(posedge clk);
               #1;
            end
         end
      join
      bus.out_ready = 1'b1;
      drain();
      bus.out_ready = 1'b0;
      send(3);
      send(4);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("async_rst_data", 32'(now_beat), 32'd0);
      sb.delete();
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      send(0);
      chk("post_rst_latency", 32'(bus.out_valid), 32'd1);
      drain();
      chk("final_idle", 32'(bus.out_valid), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
